uart_tx_feeder: RTL

Byte buffer and sequencer that sits directly upstream of the UART transmitter and drives its send/to_send inputs. System logic pushes bytes at any rate into an internal FIFO. The feeder hands them to the transmitter one at a time, waiting for tx_done between bytes. It runs in the transmitter's baud clock domain, so no clock-domain crossing is needed.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 86 ++++++++
 rtl/uart_tx_feeder.sv | 107 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
//  uart_pkg : shared types and defaults for the UART datapath blocks
//  Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   typedef logic unsigned [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } tx_feed_state_t;

   localparam int UART_FIFO_DEPTH_DEFAULT = 16;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  sync_fifo : single-clock FIFO with registered flags and overflow pulse
//  Rev 1.0   : initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             full_q;
   logic             empty_q;
   logic             overflow_q;
   logic             do_pop;
   logic             do_push;

   // A pop in the same cycle frees the slot a write into a full FIFO needs.
   assign do_pop  = pop && !empty_q;
   assign do_push = push && (!full_q || do_pop);

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q    <= count_d;
         full_q     <= (count_d == CW'(DEPTH));
         empty_q    <= (count_d == '0);
         overflow_q <= push && !do_push;
      end
   end

   assign head     = mem_q[rd_ptr_q];
   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_feeder.sv
// ============================================================================
//  uart_tx_feeder : byte queue that sequences send/to_send into a UART TX
//  Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_FIFO_DEPTH_DEFAULT,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count,
   output logic          overflow,
   output logic          send,
   output logic [7:0]    to_send,
   input  logic          tx_done,
   output logic          busy
);

   tx_feed_state_t state_q;
   byte_t          to_send_q;
   logic           send_q;
   logic           busy_q;
   logic           pop_req;
   byte_t          fifo_head;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8),
      .CW    (CW)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (pop_req),
      .head      (fifo_head),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow)
   );

   // The FIFO pops exactly when the FSM loads a new byte into to_send.
   always_comb begin
      pop_req = 1'b0;
      case (state_q)
         IDLE:    pop_req = !empty;
         WAIT:    pop_req = tx_done && !empty;
         default: pop_req = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         to_send_q <= 8'h00;
         send_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         send_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop_req) begin
                  to_send_q <= fifo_head;
                  send_q    <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= SEND;
               end
            end
            SEND: begin
               state_q <= WAIT;
            end
            WAIT: begin
               if (tx_done) begin
                  if (pop_req) begin
                     to_send_q <= fifo_head;
                     send_q    <= 1'b1;
                     state_q   <= SEND;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign send    = send_q;
   assign to_send = to_send_q;
   assign busy    = busy_q;

endmodule

`default_nettype wire
